// File: rtl/conv_stream_pkg.sv
// Shared definitions for the convolution column streamer and the address FSM bench:
// state encoding and default widths/timeouts.
package conv_stream_pkg;

    localparam int NB_IMAGE_DEF   = 10;
    localparam int NB_DATA_DEF    = 8;
    localparam int NB_TIMEOUT_DEF = 16;
    localparam int TIMEOUT_DEF    = 1023;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LD_REQ  = 4'd1,
        ST_LD_STB  = 4'd2,
        ST_LD_WAIT = 4'd3,
        ST_PROC    = 4'd4,
        ST_RD_STB  = 4'd5,
        ST_RD_CAP  = 4'd6,
        ST_RD_HOLD = 4'd7,
        ST_RD_WAIT = 4'd8,
        ST_DONE    = 4'd9
    } state_e;

    // States in which we wait on the address FSM and must guard against a hang.
    function automatic logic is_watched(input state_e s);
        return (s == ST_LD_WAIT) || (s == ST_PROC) || (s == ST_RD_WAIT);
    endfunction

endpackage

// File: rtl/conv_watchdog.sv
// Handshake watchdog: counts while enabled, restarts on clear, and flags the
// cycle in which the count would reach TIMEOUT.
module conv_watchdog #(
    parameter int NB_TIMEOUT = 16,
    parameter int TIMEOUT    = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [NB_TIMEOUT-1:0] cnt_q;
    logic [NB_TIMEOUT-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + NB_TIMEOUT'(1);
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A handshake arriving in the same cycle wins over the timeout.
    assign expire_o = en_i && !clr_i && (cnt_q == NB_TIMEOUT'(TIMEOUT - 1));

endmodule

// File: rtl/conv_frame_streamer.sv
// Host-side initiator for the column-address FSM: loads one column, starts a
// convolution pass, then streams the processed column back to the host.
module conv_frame_streamer
    import conv_stream_pkg::*;
#(
    parameter int NB_IMAGE   = NB_IMAGE_DEF,
    parameter int NB_DATA    = NB_DATA_DEF,
    parameter int NB_TIMEOUT = NB_TIMEOUT_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_IMAGE-1:0] i_imgLength,
    input  logic [NB_DATA-1:0]  i_pixel,
    input  logic                i_pixel_vld,
    output logic                o_pixel_rdy,
    output logic                o_load,
    output logic                o_SoP,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_data,
    input  logic                i_changeBlock,
    input  logic                i_EoP,
    input  logic [NB_DATA-1:0]  i_result,
    output logic [NB_DATA-1:0]  o_result,
    output logic                o_result_vld,
    input  logic                i_result_rdy,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    state_e                state_q;
    logic [NB_IMAGE-1:0]   len_q;
    logic [NB_IMAGE-1:0]   cnt_q;
    logic [NB_IMAGE-1:0]   cnt_inc;
    logic                  load_q;
    logic                  sop_q;
    logic                  valid_q;
    logic [NB_DATA-1:0]    data_q;
    logic [NB_DATA-1:0]    result_q;
    logic                  result_vld_q;
    logic                  done_q;
    logic                  error_q;
    logic                  wd_clr;
    logic                  wd_en;
    logic                  wd_expire;

    assign cnt_inc = cnt_q + NB_IMAGE'(1);

    // Leaving a watched state restarts the watchdog for the next one.
    always_comb begin
        wd_clr = 1'b0;
        case (state_q)
            ST_LD_WAIT: wd_clr = i_changeBlock;
            ST_PROC:    wd_clr = i_EoP;
            ST_RD_WAIT: wd_clr = i_changeBlock;
            default:    wd_clr = 1'b0;
        endcase
    end

    assign wd_en = is_watched(state_q);

    conv_watchdog #(
        .NB_TIMEOUT (NB_TIMEOUT),
        .TIMEOUT    (TIMEOUT)
    ) u_watchdog (
        .clk      (i_CLK),
        .rst      (i_reset),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_ff @(posedge i_CLK or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            load_q       <= 1'b0;
            sop_q        <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_imgLength != '0) begin
                            len_q   <= i_imgLength;
                            cnt_q   <= '0;
                            load_q  <= 1'b1;
                            state_q <= ST_LD_REQ;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_LD_REQ: begin
                    if (i_pixel_vld) begin
                        data_q  <= i_pixel;
                        valid_q <= 1'b1;
                        state_q <= ST_LD_STB;
                    end
                end
                ST_LD_STB: begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc == len_q) begin
                        load_q  <= 1'b0;
                        state_q <= ST_LD_WAIT;
                    end else begin
                        state_q <= ST_LD_REQ;
                    end
                end
                ST_LD_WAIT: begin
                    if (wd_expire) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (i_changeBlock) begin
                        sop_q   <= 1'b1;
                        state_q <= ST_PROC;
                    end
                end
                ST_PROC: begin
                    if (wd_expire) begin
                        sop_q   <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (i_EoP) begin
                        sop_q   <= 1'b0;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= ST_RD_STB;
                    end
                end
                ST_RD_STB: begin
                    state_q <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    result_q     <= i_result;
                    result_vld_q <= 1'b1;
                    cnt_q        <= cnt_inc;
                    state_q      <= ST_RD_HOLD;
                end
                ST_RD_HOLD: begin
                    // Single-entry output buffer: next strobe only after the host takes this word.
                    if (i_result_rdy) begin
                        result_vld_q <= 1'b0;
                        if (cnt_q == len_q) begin
                            state_q <= ST_RD_WAIT;
                        end else begin
                            valid_q <= 1'b1;
                            state_q <= ST_RD_STB;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (wd_expire) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (i_changeBlock) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_pixel_rdy  = (state_q == ST_LD_REQ);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_load       = load_q;
    assign o_SoP        = sop_q;
    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_result     = result_q;
    assign o_result_vld = result_vld_q;
    assign o_done       = done_q;
    assign o_error      = error_q;

endmodule

// File: doc/conv_frame_streamer.md
Name: conv_frame_streamer

Overview:
- Host-side initiator for the column-address FSM protocol of the 2D convolution datapath.
- Drives load / SoP / valid toward the address FSM and pushes one image column into the memory banks.
- Starts a convolution pass, then reads the processed column back out to a result stream.
- Sits between the host/GPIO interface logic and the address FSM plus memory banks.

Parameters:
- NB_IMAGE, 10, width of column length and word counter.
- NB_DATA, 8, pixel/result word width.
- NB_TIMEOUT, 16, width of handshake watchdog counter.
- TIMEOUT, 1023, cycles allowed waiting for i_changeBlock or i_EoP before error.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_reset  in  1  reset; asynchronous, active-high.
- i_start  in  1  one-cycle request to run load, process and readback for one column.
- i_imgLength  in  NB_IMAGE  words per column; sampled on accepted i_start.
- i_pixel  in  NB_DATA  host pixel word.
- i_pixel_vld  in  1  host pixel valid.
- o_pixel_rdy  out  1  streamer accepts i_pixel this cycle.
- o_load  out  1  load request to address FSM.
- o_SoP  out  1  start-of-process to address FSM.
- o_valid  out  1  word strobe to address FSM; FSM counts its rising edge.
- o_data  out  NB_DATA  memory write data, stable while o_valid is high.
- i_changeBlock  in  1  FSM finished load/read block.
- i_EoP  in  1  FSM end of process.
- i_result  in  NB_DATA  memory read data.
- o_result  out  NB_DATA  result word to host.
- o_result_vld  out  1  result valid; held until accepted.
- i_result_rdy  in  1  host accepts o_result.
- o_busy  out  1  high outside IDLE.
- o_done  out  1  one-cycle pulse when readback completes.
- o_error  out  1  one-cycle pulse on timeout or zero-length start.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; word counter 0; latched length 0; watchdog 0. Reset mid-operation aborts immediately with no completion pulse.
- States: IDLE, LD_REQ, LD_STB, LD_WAIT, PROC, RD_STB, RD_CAP, RD_HOLD, RD_WAIT, DONE.
- IDLE:
  - On i_start with i_imgLength != 0: latch length, clear counter, o_load<=1, go to LD_REQ.
  - On i_start with i_imgLength == 0: o_error pulse, stay in IDLE.
  - i_start is ignored while o_busy.
- LD_REQ: o_pixel_rdy=1 (combinational from state). On i_pixel_vld, register i_pixel into o_data and go to LD_STB.
- LD_STB:
  - o_valid high for exactly this one cycle; counter+1.
  - If counter+1 == length: o_load<=0, go to LD_WAIT. Else go to LD_REQ.
  - LD_REQ always drives o_valid low, so every strobe is followed by at least one low cycle. Minimum 2 cycles per word.
- LD_WAIT: wait for i_changeBlock=1, then assert o_SoP and go to PROC.
- PROC:
  - o_SoP held high until i_EoP=1.
  - Then o_SoP<=0, clear counter, go to RD_STB. o_load stays 0.
- RD_STB: o_valid high for one cycle; go to RD_CAP.
- RD_CAP: o_valid low; register i_result into o_result, o_result_vld<=1, counter+1; go to RD_HOLD.
- RD_HOLD:
  - Wait for i_result_rdy; on handshake o_result_vld<=0.
  - Next state is RD_WAIT if counter == length, else RD_STB.
  - No new strobe is issued while a result is pending (single-entry output buffer, no overwrite).
- RD_WAIT: wait for i_changeBlock, then go to DONE.
- DONE: o_done pulse, return to IDLE.
- Watchdog:
  - Counts in LD_WAIT, PROC and RD_WAIT; cleared on every state change.
  - Reaching TIMEOUT: o_error pulse, all strobes 0, go to IDLE.
- i_changeBlock or i_EoP arriving in any other state is ignored.
- Counter compare uses full NB_IMAGE width; length 2^NB_IMAGE-1 is legal. Counter never wraps because the compare precedes the increment.
- Simultaneous i_start and i_reset: reset wins.

Decomposition:
- Shared package conv_stream_pkg: state encoding constants, NB_IMAGE/NB_DATA defaults, TIMEOUT default. These are shared with the address FSM bench.
- One natural sub-module: conv_watchdog (load/clear/enable counter with terminal pulse). Everything else stays flat.

Test Plan:
- Load path: length=4, pixels 0x11,0x12,0x13,0x14 with i_pixel_vld always high -> exactly 4 single-cycle o_valid pulses separated by at least 1 low cycle; o_data matches each word; o_load falls in the cycle after the 4th strobe.
- Full column: drive i_changeBlock 3 cycles after load ends, i_EoP 20 cycles after SoP, i_result=0xA0+n -> o_SoP high until i_EoP; 4 results 0xA0..0xA3 in order; then i_changeBlock -> o_done pulse, o_busy low.
- Backpressure: hold i_result_rdy low 10 cycles on the 2nd result -> o_result_vld and o_result stable; no o_valid strobe until accepted.
- Timeout: TIMEOUT=16, never assert i_EoP -> o_error pulse 16 cycles after PROC entry; o_SoP=0; state IDLE.
- Boundaries: i_start with length=0 -> o_error, no o_load. i_start while busy -> ignored.
- Async reset mid-load (after 2 of 4 strobes, asserted between clock edges) -> all outputs 0 immediately, no o_done; a new i_start then runs a clean full column.
